retire_trace_buffer: RTL

Buffers one retirement record per committed instruction from the single-cycle core: PC, instruction word, format class and register write-back. Records drain through a valid/ready port to the trace comparator. Sits directly downstream of `top`, sampling its retire-side signals. Detects the exit syscall and reports when all records up to and including it have drained. Flags and counts any records lost to overflow.

---
 rtl/trace_pkg.sv | 33 +++
 rtl/trace_fifo_mem.sv | 75 +++++++
 rtl/retire_trace_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the retirement trace buffer.
//   trace_kind_e : format class of a retired instruction
//   trace_rec_t  : one buffered retirement record
//   trc_state_e  : capture FSM states
package trace_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_R    = 2'd1,
    KIND_I    = 2'd2,
    KIND_J    = 2'd3
  } trace_kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    trace_kind_e kind;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] seq;
  } trace_rec_t;

  localparam logic [31:0] TRC_SYSCALL_INSTR = 32'h0000000C;
  localparam logic [31:0] TRC_EXIT_V0       = 32'h0000000A;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    STOP = 2'd1,
    DONE = 2'd2
  } trc_state_e;

endpackage

// File: rtl/trace_fifo_mem.sv
// Record storage for the trace buffer with a registered head register.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   push, wdata    : write one record (caller guarantees a free slot or a same-cycle pop)
//   pop            : consume the head (caller guarantees head_valid)
//   head, head_valid : registered copy of the oldest record
//   level          : occupied entries, 0..DEPTH (includes the head)
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  trace_rec_t               wdata,
  output trace_rec_t               head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;

  assign rd_ptr_nx = rd_ptr + PTR_W'(1);

  // Storage array carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and head register. The head mirrors mem[rd_ptr];
  // when the next head is the entry being written this cycle it is taken
  // straight from wdata so there is no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nx;

      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (pop) begin
        if (level > LVL_W'(1)) begin
          head       <= mem[rd_ptr_nx];
          head_valid <= 1'b1;
        end else if (push) begin
          head       <= wdata;
          head_valid <= 1'b1;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (push && (level == '0)) begin
        head       <= wdata;
        head_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: captures one record per retired instruction,
// drains them over a valid/ready port, detects the exit syscall and flags
// records lost to overflow.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   ret_*           : retire-side record fields from the core, ret_v0 = r2
//   trc_valid/ready : head handshake; trc_* head fields, trc_seq sequence number
//   level           : occupied entries
//   overflow        : sticky drop flag; drop_cnt saturating drop count
//   clr_ovf         : synchronous clear of overflow and drop_cnt
//   eot, done       : exit captured / exit captured and buffer drained
// Configuration macro: TRACE_NOP_FILTER_EN (skip storing all-zero instruction words).
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ret_valid,
  input  logic [31:0]            ret_pc,
  input  logic [31:0]            ret_instr,
  input  logic [1:0]             ret_kind,
  input  logic                   ret_wr_en,
  input  logic [4:0]             ret_wr_reg,
  input  logic [31:0]            ret_wr_data,
  input  logic [31:0]            ret_v0,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [31:0]            trc_pc,
  output logic [31:0]            trc_instr,
  output logic [1:0]             trc_kind,
  output logic                   trc_wr_en,
  output logic [4:0]             trc_wr_reg,
  output logic [31:0]            trc_wr_data,
  output logic [31:0]            trc_seq,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_ovf,
  output logic                   eot,
  output logic                   done
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  trc_state_e  state;
  logic [31:0] seq;
  trace_rec_t  wrec;
  trace_rec_t  head;
  logic        head_valid;
  logic        nop;
  logic        rv;
  logic        want_push;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        exit_hit;

`ifdef TRACE_NOP_FILTER_EN
  assign nop = (ret_instr == 32'h0000_0000);
`else
  assign nop = 1'b0;
`endif

  // Retirements only count while capturing; STOP and DONE ignore them.
  assign rv        = ret_valid && (state == RUN);
  assign want_push = rv && !nop;
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = head_valid && trc_ready;
  // A same-cycle pop frees the slot a full-buffer push needs.
  assign push      = want_push && (!full || pop);
  assign drop      = want_push && full && !pop;
  // Exit is recognised whether the record is stored or dropped.
  assign exit_hit  = want_push && (ret_instr == TRC_SYSCALL_INSTR) && (ret_v0 == TRC_EXIT_V0);

  always_comb begin
    wrec         = '0;
    wrec.pc      = ret_pc;
    wrec.instr   = ret_instr;
    wrec.kind    = trace_kind_e'(ret_kind);
    wrec.wr_en   = ret_wr_en;
    wrec.wr_reg  = ret_wr_reg;
    wrec.wr_data = ret_wr_data;
    wrec.seq     = seq;
  end

  trace_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .wdata      (wrec),
    .head       (head),
    .head_valid (head_valid),
    .level      (level)
  );

  // Capture FSM with sequence counter, drop accounting and exit status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      eot      <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (rv) seq <= seq + 32'd1;

      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end

      unique case (state)
        RUN: begin
          if (exit_hit) begin
            eot   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (level == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    done  <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  assign trc_valid   = head_valid;
  assign trc_pc      = head.pc;
  assign trc_instr   = head.instr;
  assign trc_kind    = head.kind;
  assign trc_wr_en   = head.wr_en;
  assign trc_wr_reg  = head.wr_reg;
  assign trc_wr_data = head.wr_data;
  assign trc_seq     = head.seq;

endmodule
